dmem_loader: RTL and testbench



---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_port_mux.sv | 33 +++
 rtl/dmem_loader.sv | 108 ++++++++++
 tb/tb_dmem_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory loader.
// Holds the loader state enum, the default RAM depth and word-to-byte address conversion.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } ldr_state_t;

  localparam int DEPTH_DEFAULT = 512;

  function automatic logic [63:0] word_to_byte(input logic [63:0] word_index);
    return word_index << 2;
  endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// dmem_port_mux: 2:1 select of the RAM write port between the loader and the CPU.
// Latency: purely combinational. Backpressure: none; block_we squashes any write.
module dmem_port_mux #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          sel_ldr,
  input  logic          block_we,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_din,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din
);

  always_comb begin
    if (sel_ldr) begin
      ram_we   = ldr_we;
      ram_addr = ldr_addr;
      ram_din  = ldr_din;
    end else begin
      ram_we   = cpu_we;
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
    end
    if (block_we) ram_we = 1'b0;
  end

endmodule

// File: rtl/dmem_loader.sv
// dmem_loader: fills the data RAM from a valid/ready word stream, then passes the CPU port through.
// Latency: zero, each accepted word is written on its accepting edge. Backpressure: s_ready only in LOAD.
// Optional DMEM_LOADER_CHECKSUM_EN adds a running additive checksum of the loaded words.
module dmem_loader
  import dmem_pkg::*;
#(
  parameter int            DEPTH     = DEPTH_DEFAULT,
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   s_valid,
  input  logic [DW-1:0]          s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  input  logic                   cpu_we,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_din,
  output logic                   ram_we,
  output logic [AW-1:0]          ram_addr,
  output logic [DW-1:0]          ram_din,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [$clog2(DEPTH):0] word_count,
  output logic [DW-1:0]          checksum
);

  localparam int CW = $clog2(DEPTH) + 1;

  ldr_state_t    state, state_nxt;
  logic          in_range;
  logic          ldr_we;
  logic          clr_count;
  logic [AW-1:0] ldr_addr;

  assign in_range = (word_count < CW'(DEPTH));
  assign s_ready  = (state == LOAD);
  assign ldr_we   = s_ready & s_valid & in_range;
  assign ldr_addr = BASE_ADDR + AW'(word_to_byte(64'(word_count)));

  assign busy = (state == LOAD);
  assign done = (state == DONE);
  assign err  = (state == ERR);

  always_comb begin
    state_nxt = state;
    clr_count = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nxt = LOAD;
          clr_count = 1'b1;
        end
      end
      LOAD: begin
        // A word arriving with the RAM already full is an overflow, never written.
        if (s_valid) begin
          if (!in_range)   state_nxt = ERR;
          else if (s_last) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (clr_count)   word_count <= '0;
      else if (ldr_we) word_count <= word_count + 1'b1;
    end
  end

`ifdef DMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || clr_count) checksum <= '0;
    else if (ldr_we)      checksum <= checksum + s_data;
  end
`else
  assign checksum = '0;
`endif

  // Reset squashes writes so an aborted load cannot corrupt the word it was on.
  dmem_port_mux #(
    .AW(AW),
    .DW(DW)
  ) u_port_mux (
    .sel_ldr  (busy),
    .block_we (rst),
    .ldr_we   (ldr_we),
    .ldr_addr (ldr_addr),
    .ldr_din  (s_data),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din)
  );

endmodule

// File: tb/tb_dmem_loader.sv
// Bench for dmem_loader: directed vector table, hand-written RAM retention checks,
// then randomized traffic against a behavioural model of the loader.
module tb_dmem_loader;

  localparam int          DEPTH = 4;
  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] C_A   = 32'h0000_0010;
  localparam logic [31:0] C_D   = 32'hDEAD_BEEF;
`ifdef DMEM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_last, cpu_we;
  logic [DW-1:0] s_data, cpu_din, ram_din, checksum;
  logic [AW-1:0] cpu_addr, ram_addr;
  logic          s_ready, ram_we, busy, done, err;
  logic [CW-1:0] word_count;
  logic [31:0]   mem [64];
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  dmem_loader #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .busy(busy), .done(done), .err(err), .word_count(word_count), .checksum(checksum)
  );

  // Behavioural RAM sitting behind the loader.
  always @(posedge clk) if (ram_we) mem[ram_addr[7:2]] <= ram_din;

  typedef struct {
    logic        rst, start, vld, last, cwe;
    logic [31:0] dat;
    logic        e_we;
    logic [31:0] e_addr, e_din;
    logic        e_busy, e_done, e_err;
    int          e_cnt;
    logic [31:0] e_sum;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, st, v, l, c, input logic [31:0] d,
                              input logic we, input logic [31:0] a, dn,
                              input logic b, dne, er, input int cnt, input logic [31:0] sm);
    vec_t x;
    x.rst = r; x.start = st; x.vld = v; x.last = l; x.cwe = c; x.dat = d;
    x.e_we = we; x.e_addr = a; x.e_din = dn;
    x.e_busy = b; x.e_done = dne; x.e_err = er; x.e_cnt = cnt; x.e_sum = sm;
    return x;
  endfunction

  task automatic check(input string name, input logic we, input logic [31:0] a, dn,
                       input logic b, dne, er, input int cnt, input logic [31:0] sm);
    logic [31:0] want_sum;
    bit ok;
    want_sum = CK_EN ? sm : 32'h0;
    ok = (ram_we === we) && (busy === b) && (s_ready === b) && (done === dne) &&
         (err === er) && (word_count === CW'(cnt)) && (checksum === want_sum);
    if (we) ok = ok && (ram_addr === a) && (ram_din === dn);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got we=%b addr=%h din=%h busy=%b rdy=%b done=%b err=%b cnt=%0d sum=%h; want we=%b addr=%h din=%h busy=%b done=%b err=%b cnt=%0d sum=%h",
               name, ram_we, ram_addr, ram_din, busy, s_ready, done, err, word_count, checksum,
               we, a, dn, b, dne, er, cnt, want_sum);
    end
  endtask

  task automatic check_mem(input string name, input int idx, input logic [31:0] want);
    tests++;
    if (mem[idx] !== want) begin
      fails++;
      $display("FAIL %s: mem[%0d]=%h want %h", name, idx, mem[idx], want);
    end
  endtask

  // Model state for the random phase.
  bit          m_load, m_done, m_err;
  int          m_cnt;
  logic [31:0] m_sum;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    cpu_we = 1'b0; cpu_addr = C_A; cpu_din = C_D;
    repeat (2) @(posedge clk);
    #1;

    //         rst st vld lst cwe dat       we  addr       din        bsy dn er cnt sum
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0,  0, 32'h0,     32'h0,     0, 0, 0, 0, 32'h0));   // reset state
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,  1, C_A,       C_D,       0, 0, 0, 0, 32'h0));   // idle pass-through
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,     32'h0,     0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h11, 1, BASE,      32'h11,    1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h22, 1, BASE+4,    32'h22,    1, 0, 0, 1, 32'h11));
    tbl.push_back(mk(0, 0, 1, 1, 1, 32'h33, 1, BASE+8,    32'h33,    1, 0, 0, 2, 32'h33));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,     32'h0,     0, 1, 0, 3, 32'h66));  // DONE
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0,  1, C_A,       C_D,       0, 1, 0, 3, 32'h66));  // reload
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,  0, 32'h0,     32'h0,     1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'hA0, 1, BASE,      32'hA0,    1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,  0, 32'h0,     32'h0,     1, 0, 0, 1, 32'hA0));  // gap
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,  0, 32'h0,     32'h0,     1, 0, 0, 1, 32'hA0));  // gap
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'hB0, 1, BASE+4,    32'hB0,    1, 0, 0, 1, 32'hA0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'hC0, 1, BASE+8,    32'hC0,    1, 0, 0, 2, 32'h150));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'hD0, 1, BASE+12,   32'hD0,    1, 0, 0, 3, 32'h210));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'hE0, 0, 32'h0,     32'h0,     1, 0, 0, 4, 32'h2E0)); // overflow
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,  1, C_A,       C_D,       0, 0, 1, 4, 32'h2E0)); // ERR
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,     32'h0,     0, 0, 1, 4, 32'h2E0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h5,  1, BASE,      32'h5,     1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h6,  1, BASE+4,    32'h6,     1, 0, 0, 1, 32'h5));
    tbl.push_back(mk(1, 0, 1, 0, 0, 32'h7,  0, 32'h0,     32'h0,     1, 0, 0, 2, 32'hB));   // rst mid-load
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h8,  0, 32'h0,     32'h0,     0, 0, 0, 0, 32'h0));   // back in IDLE

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; start = tbl[i].start; s_valid = tbl[i].vld;
      s_last = tbl[i].last; cpu_we = tbl[i].cwe; s_data = tbl[i].dat;
      cpu_addr = C_A; cpu_din = C_D;
      #1;
      check($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_addr, tbl[i].e_din,
            tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err, tbl[i].e_cnt, tbl[i].e_sum);
      @(posedge clk);
      #1;
    end

    // RAM contents: reloaded words, words kept from the earlier load, nothing written by reset.
    check_mem("ram_w0", 0, 32'h5);
    check_mem("ram_w1", 1, 32'h6);
    check_mem("ram_w2_kept", 2, 32'hC0);
    check_mem("ram_w3_kept", 3, 32'hD0);

    m_load = 0; m_done = 0; m_err = 0; m_cnt = 0; m_sum = '0;
    for (int n = 0; n < 800; n++) begin
      logic        exp_we;
      logic [31:0] exp_a, exp_d;
      rst      = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 7) == 0);
      s_valid  = 1'($urandom_range(0, 1));
      s_last   = ($urandom_range(0, 4) == 0);
      cpu_we   = 1'($urandom_range(0, 1));
      s_data   = $urandom;
      cpu_addr = 32'($urandom_range(0, 63)) << 2;
      cpu_din  = $urandom;
      #1;
      if (m_load) begin
        exp_we = s_valid && (m_cnt < DEPTH);
        exp_a  = BASE + 32'(m_cnt) * 4;
        exp_d  = s_data;
      end else begin
        exp_we = cpu_we;
        exp_a  = cpu_addr;
        exp_d  = cpu_din;
      end
      if (rst) exp_we = 1'b0;
      check($sformatf("rand%0d", n), exp_we, exp_a, exp_d, m_load, m_done, m_err, m_cnt, m_sum);
      @(posedge clk);
      #1;
      if (rst) begin
        m_load = 0; m_done = 0; m_err = 0; m_cnt = 0; m_sum = '0;
      end else if (m_load) begin
        if (s_valid) begin
          if (m_cnt < DEPTH) begin
            m_cnt++;
            m_sum = m_sum + s_data;
            if (s_last) begin m_load = 0; m_done = 1; end
          end else begin
            m_load = 0; m_err = 1;
          end
        end
      end else if (start) begin
        m_load = 1; m_done = 0; m_err = 0; m_cnt = 0; m_sum = '0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
